// File: rtl/edf_queue_arbiter.sv
// rtl/edf_queue_arbiter.sv - earliest-deadline-first grant of per-core request queues to the serializer
module edf_queue_arbiter #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32,
  localparam int IDW             = $clog2(NUMBER_OF_QUEUES)
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic [NUMBER_OF_QUEUES-1:0]                     empty,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]  periods,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]  deadlines,
  input  logic                                            counter_reset,
  input  logic                                            consumed,
  output logic [IDW-1:0]                                  id,
  output logic                                            enable,
  output logic [NUMBER_OF_QUEUES-1:0]                     hasBeenConsumed,
  output logic [NUMBER_OF_QUEUES-1:0]                     deadline_miss
);

  localparam logic [REGISTER_SIZE-1:0]    ONE     = 1;
  localparam logic [NUMBER_OF_QUEUES-1:0] ONE_HOT = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t                                           state_q;
  logic [IDW-1:0]                                   id_q;
  logic                                             enable_q;
  logic [NUMBER_OF_QUEUES-1:0]                      pop_q;

  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   pc_q, pc_d;
  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   rd_q, rd_d;
  logic [NUMBER_OF_QUEUES-1:0]                      miss_q, miss_d;
  // Set by reset so the first clock after release samples the deadlines.
  logic                                             load_q;

  logic                                             win_valid;
  logic [IDW-1:0]                                   win_id;
  logic [REGISTER_SIZE-1:0]                         win_rd;

  assign id              = id_q;
  assign enable          = enable_q;
  assign hasBeenConsumed = pop_q;
  assign deadline_miss   = miss_q;

  // Next state of the per-queue period and remaining-deadline counters and miss flags.
  always_comb begin
    pc_d   = pc_q;
    rd_d   = rd_q;
    miss_d = miss_q;
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      if (counter_reset || load_q) begin
        pc_d[i] = '0;
        rd_d[i] = deadlines[i];
        if (counter_reset) begin
          miss_d[i] = 1'b0;
        end
      end else if (periods[i] == '0) begin
        // No real-time constraint: park at the lowest urgency.
        pc_d[i] = '0;
        rd_d[i] = '1;
      end else if (pc_q[i] >= periods[i] - ONE) begin
        // >= also recovers if the period is shortened below the running count.
        pc_d[i] = '0;
        rd_d[i] = deadlines[i];
      end else begin
        pc_d[i] = pc_q[i] + ONE;
        if (rd_q[i] != '0) begin
          rd_d[i] = rd_q[i] - ONE;
        end
        if (rd_q[i] == ONE && !empty[i]) begin
          miss_d[i] = 1'b1;
        end
      end
    end
  end

  // Counter and miss-flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q   <= '0;
      rd_q   <= '1;
      miss_q <= '0;
      load_q <= 1'b1;
    end else begin
      pc_q   <= pc_d;
      rd_q   <= rd_d;
      miss_q <= miss_d;
      load_q <= 1'b0;
    end
  end

  // Pick the nonempty queue with the smallest remaining deadline; ties go to the lowest index.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    win_rd    = '1;
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      if (!empty[i] && (!win_valid || rd_q[i] < win_rd)) begin
        win_valid = 1'b1;
        win_id    = IDW'(i);
        win_rd    = rd_q[i];
      end
    end
  end

  // Grant FSM: a grant is held without preemption until consumed or aborted by its queue emptying.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      enable_q <= 1'b0;
      pop_q    <= '0;
    end else begin
      pop_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            id_q     <= win_id;
            enable_q <= 1'b1;
            state_q  <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (consumed) begin
            pop_q    <= ONE_HOT << id_q;
            enable_q <= 1'b0;
            state_q  <= S_RELEASE;
          end else if (empty[id_q]) begin
            enable_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        S_RELEASE: begin
          // Gives the popped queue's empty flag a cycle to settle before re-arbitrating.
          state_q <= S_IDLE;
        end
        default: begin
          enable_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edf_queue_arbiter.sv
// tb/tb_edf_queue_arbiter.sv - scoreboard bench for edf_queue_arbiter
module tb_edf_queue_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic                clock = 1'b0;
  logic                reset;
  logic [N-1:0]        empty;
  logic [N-1:0][W-1:0] periods;
  logic [N-1:0][W-1:0] deadlines;
  logic                counter_reset;
  logic                consumed;
  logic [1:0]          id;
  logic                enable;
  logic [N-1:0]        hasBeenConsumed;
  logic [N-1:0]        deadline_miss;

  edf_queue_arbiter #(.NUMBER_OF_QUEUES(N), .REGISTER_SIZE(W)) dut (
    .clock           (clock),
    .reset           (reset),
    .empty           (empty),
    .periods         (periods),
    .deadlines       (deadlines),
    .counter_reset   (counter_reset),
    .consumed        (consumed),
    .id              (id),
    .enable          (enable),
    .hasBeenConsumed (hasBeenConsumed),
    .deadline_miss   (deadline_miss)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int           exp_grant[$];
  logic [N-1:0] exp_pop[$];

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every new grant and every pop pulse is matched against the scoreboard.
  logic prev_en = 1'b0;
  always @(negedge clock) begin
    int           eg;
    logic [N-1:0] ep;
    if (enable && !prev_en) begin
      eg = (exp_grant.size() != 0) ? exp_grant.pop_front() : 99;
      check("grant_id", 32'(id), 32'(eg));
    end
    if (hasBeenConsumed != '0) begin
      ep = (exp_pop.size() != 0) ? exp_pop.pop_front() : '0;
      check("pop_vector", 32'(hasBeenConsumed), 32'(ep));
    end
    prev_en = enable;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_cr();
    counter_reset = 1'b1;
    tick(1);
    counter_reset = 1'b0;
  endtask

  task automatic wait_pop(output logic [N-1:0] v);
    int k = 0;
    while (hasBeenConsumed == '0 && k < 20) begin
      tick(1);
      k++;
    end
    v = hasBeenConsumed;
    if (v == '0) check("pop_timeout", 32'(v), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] v;
    int           bad;
    int           last;

    reset         = 1'b0;
    empty         = '1;
    periods       = '0;
    deadlines     = '0;
    counter_reset = 1'b0;
    consumed      = 1'b0;
    tick(2);
    check("reset_enable", 32'(enable), 32'd0);
    check("reset_pop", 32'(hasBeenConsumed), 32'd0);
    check("reset_miss", 32'(deadline_miss), 32'd0);
    check("reset_id", 32'(id), 32'd0);
    reset = 1'b1;

    // All queues empty, no real-time constraints: nothing is ever granted.
    bad = 0;
    repeat (100) begin
      tick(1);
      if (enable !== 1'b0 || hasBeenConsumed !== '0 || id !== 2'd0) bad++;
    end
    check("idle_100_cycles", 32'(bad), 32'd0);

    // EDF order; each queue holds a single packet so a pop empties it.
    periods      = {4{32'd100}};
    deadlines[0] = 32'd40;
    deadlines[1] = 32'd10;
    deadlines[2] = 32'd30;
    deadlines[3] = 32'd20;
    pulse_cr();
    exp_grant.push_back(1); exp_grant.push_back(3); exp_grant.push_back(2); exp_grant.push_back(0);
    exp_pop.push_back(4'b0010); exp_pop.push_back(4'b1000);
    exp_pop.push_back(4'b0100); exp_pop.push_back(4'b0001);
    empty = '0;
    tick(1);
    check("first_grant_latency", 32'(enable), 32'd1);
    check("first_grant_id", 32'(id), 32'd1);
    consumed = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_pop(v);
      empty = empty | v;
      tick(1);
      check("pop_one_cycle", 32'(hasBeenConsumed), 32'd0);
    end
    consumed = 1'b0;
    tick(3);
    check("order_done_idle", 32'(enable), 32'd0);

    // Equal deadlines: lowest index wins; an eager consumer sees one pop per 3 cycles.
    deadlines = {4{32'd50}};
    pulse_cr();
    for (int k = 0; k < 4; k++) begin
      exp_grant.push_back(0);
      exp_pop.push_back(4'b0001);
    end
    empty    = '0;
    consumed = 1'b1;
    last     = -1;
    for (int k = 0; k < 4; k++) begin
      wait_pop(v);
      if (k > 0) check("pop_spacing", 32'(cyc - last), 32'd3);
      last = cyc;
      tick(1);
    end
    consumed = 1'b0;
    empty    = '1;
    tick(3);

    // Abort: granted queue empties without being consumed, then re-arbitration.
    deadlines[0] = 32'd40;
    deadlines[1] = 32'd10;
    deadlines[2] = 32'd30;
    deadlines[3] = 32'd20;
    pulse_cr();
    exp_grant.push_back(1);
    exp_grant.push_back(3);
    empty = 4'b0101;
    tick(1);
    check("abort_grant_up", 32'(enable), 32'd1);
    tick(2);
    empty[1] = 1'b1;
    tick(1);
    check("abort_enable_drop", 32'(enable), 32'd0);
    check("abort_no_pop", 32'(hasBeenConsumed), 32'd0);
    tick(1);
    check("abort_regrant", 32'(enable), 32'd1);
    empty = '1;
    tick(3);

    // Deadline miss on queue 2: set five cycles after restart, sticky across a wrap.
    periods      = '0;
    periods[2]   = 32'd20;
    deadlines    = '0;
    deadlines[2] = 32'd5;
    empty        = 4'b1011;
    exp_grant.push_back(2);
    pulse_cr();
    tick(4);
    check("miss_not_early", 32'(deadline_miss), 32'd0);
    tick(1);
    check("miss_set", 32'(deadline_miss), 32'h4);
    tick(16);
    check("miss_sticky_wrap", 32'(deadline_miss), 32'h4);
    pulse_cr();
    check("miss_cleared", 32'(deadline_miss), 32'd0);
    tick(5);
    check("miss_set_again", 32'(deadline_miss), 32'h4);

    // Asynchronous reset in the middle of a grant; counters restart on release.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_enable", 32'(enable), 32'd0);
    check("async_reset_miss", 32'(deadline_miss), 32'd0);
    exp_grant.push_back(2);
    tick(2);
    reset = 1'b1;
    tick(5);
    check("restart_no_early_miss", 32'(deadline_miss), 32'd0);
    tick(1);
    check("restart_miss", 32'(deadline_miss), 32'h4);
    empty = '1;
    tick(3);

    check("grant_queue_drained", 32'(exp_grant.size()), 32'd0);
    check("pop_queue_drained", 32'(exp_pop.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
